// File: rtl/p6_defs.sv
// Shared constants for the parity serial transmitter and anything that decodes
// its status output (e.g. a receiver-side bench).
package p6_defs;

  // Status / state encoding; codes 4..7 are unused.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DATA   = 3'd1;
  localparam logic [2:0] S_PARITY = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;

  // Bit-counter width for a frame of dw data bits (counts dw-1 down to 0).
  function automatic int cnt_w(input int dw);
    return (dw <= 2) ? 1 : $clog2(dw);
  endfunction

endpackage

// File: rtl/p6_shift_parity.sv
// Loadable left-shift register with running XOR.
// The register holds the bits still to be sent, so msb_out is always the NEXT
// data bit; the MSB itself goes straight out on the load edge and seeds the
// parity. Each shift folds the bit being sent into the running parity.
module p6_shift_parity #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] data_in,
  output logic              msb_out,
  output logic              parity_out
);

  logic [DATA_W-1:0] r_sr;
  logic              r_par;

  // Load drops the MSB (sent on the load edge); shift consumes one bit per edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sr  <= '0;
      r_par <= 1'b0;
    end else if (load) begin
      r_sr  <= {data_in[DATA_W-2:0], 1'b0};
      r_par <= data_in[DATA_W-1];
    end else if (shift) begin
      r_sr  <= {r_sr[DATA_W-2:0], 1'b0};
      r_par <= r_par ^ r_sr[DATA_W-1];
    end
  end

  assign msb_out    = r_sr[DATA_W-1];
  assign parity_out = r_par;

endmodule

// File: rtl/p6_parity_serial_tx.sv
// Serial transmitter: sends a DATA_W-bit word MSB first, then one parity bit
// making the frame's ones count even (PARITY_EVEN=1) or odd (PARITY_EVEN=0).
// All outputs are registered from next-state decode.
module p6_parity_serial_tx
  import p6_defs::*;
#(
  parameter int DATA_W      = 8,
  parameter bit PARITY_EVEN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              tx_bit,
  output logic              tx_valid,
  output logic              busy,
  output logic              done,
  output logic [2:0]        status
);

  localparam int CNT_W = cnt_w(DATA_W);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_last;
  logic             w_shift;
  logic             w_msb;
  logic             w_par;
  logic             w_tx_bit_nxt;
  logic             w_tx_valid_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             r_tx_bit;
  logic             r_tx_valid;
  logic             r_busy;
  logic             r_done;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_cnt == '0);
  assign w_shift  = (r_state == S_DATA) && !w_last;

  p6_shift_parity #(.DATA_W(DATA_W)) u_sp (
    .clk        (clk),
    .reset      (reset),
    .load       (w_accept),
    .shift      (w_shift),
    .data_in    (data_in),
    .msb_out    (w_msb),
    .parity_out (w_par)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; unused codes fall back to IDLE.
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:   w_state_nxt = start  ? S_DATA   : S_IDLE;
      S_DATA:   w_state_nxt = w_last ? S_PARITY : S_DATA;
      S_PARITY: w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Next output values, decoded from the state being entered.
  always_comb begin
    w_tx_valid_nxt = (w_state_nxt == S_DATA) || (w_state_nxt == S_PARITY);
    w_busy_nxt     = w_tx_valid_nxt || (w_state_nxt == S_DONE);
    w_done_nxt     = (w_state_nxt == S_DONE);
    w_tx_bit_nxt   = 1'b0;
    case (r_state)
      S_IDLE:  w_tx_bit_nxt = start & data_in[DATA_W-1];
      S_DATA:  w_tx_bit_nxt = w_last ? (PARITY_EVEN ? w_par : ~w_par) : w_msb;
      default: w_tx_bit_nxt = 1'b0;
    endcase
  end

  // Bit counter: loaded on acceptance, counts down through the data bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_cnt <= '0;
    else if (w_accept) r_cnt <= CNT_W'(DATA_W - 1);
    else if (w_shift)  r_cnt <= r_cnt - 1'b1;
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_bit   <= 1'b0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign tx_bit   = r_tx_bit;
  assign tx_valid = r_tx_valid;
  assign busy     = r_busy;
  assign done     = r_done;
  assign status   = r_state;

endmodule

// File: doc/p6_parity_serial_tx.md
Name: p6_parity_serial_tx

Overview:
Serial transmitter that generates the bit stream consumed by the parity-detecting FSM. It accepts a parallel word on a start strobe and shifts it out one bit per clock, MSB first. It then appends one parity bit, so the receiving parity FSM sees a frame whose total count of ones is even (or odd, per parameter). It sits upstream of P5_FSM_1par_0impar: tx_bit drives that block's x input.

Parameters:
DATA_W, 8, number of data bits per frame (2..16)
PARITY_EVEN, 1, 1 = even parity bit appended, 0 = odd parity bit appended

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  frame request, sampled only in IDLE
data_in  input  DATA_W  word to transmit, latched when start is accepted
tx_bit  output  1  serial data/parity bit, registered
tx_valid  output  1  high while tx_bit carries a data or parity bit
busy  output  1  high from the cycle after start acceptance until return to IDLE
done  output  1  one-cycle pulse after the parity bit
status  output  3  current state encoding, for debug and bench visibility

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, port name reset. While reset=0, every output is forced immediately: tx_bit=0, tx_valid=0, busy=0, done=0, status=3'd0, state=IDLE. Internal shift register, bit counter and running parity are also cleared.
- State encoding on status: IDLE=3'd0, DATA=3'd1, PARITY=3'd2, DONE=3'd3. Codes 4..7 are unused; any unused code goes to IDLE on the next edge.
- IDLE:
  - Outputs idle (tx_valid=0, busy=0, done=0, tx_bit=0).
  - On an edge with start=1: latch data_in into the shift register, load counter=DATA_W-1, go to DATA.
  - On that same edge, register tx_bit=data_in[DATA_W-1] and seed running parity with that bit.
- DATA:
  - tx_valid=1, busy=1.
  - Each edge: shift left, tx_bit takes the next bit, running parity ^= that bit, counter decrements.
  - When counter=0 at an edge, go to PARITY.
  - tx_bit = accumulated XOR of all DATA_W bits when PARITY_EVEN=1, or its inverse when PARITY_EVEN=0.
- PARITY: tx_valid=1, busy=1 for one cycle, then go to DONE.
- DONE: tx_valid=0, busy=1, done=1 for one cycle, tx_bit=0, then go to IDLE.
- Latency: start accepted at edge k.
  - Data bits are valid in cycles k+1..k+DATA_W.
  - Parity bit is valid in cycle k+DATA_W+1.
  - done is high in cycle k+DATA_W+2.
  - The next start can be accepted at edge k+DATA_W+3.
- Frame length: exactly DATA_W+1 tx_valid cycles.
- start outside IDLE (DATA, PARITY, DONE) is ignored, not queued. data_in changes after acceptance have no effect.
- start held high continuously gives back-to-back frames separated by the DONE cycle plus the IDLE acceptance cycle.
- Reset asserted mid-frame aborts immediately with no done pulse. After reset release, the block waits in IDLE for a fresh start.
- All outputs are registered; no combinational path from start or data_in to any output.

Decomposition:
- Shared package (or include file) p6_defs holds:
  - state localparams S_IDLE, S_DATA, S_PARITY, S_DONE as 3-bit values;
  - the counter width, computed as $clog2(DATA_W).
- The receiver bench reuses the same constants to decode status.
- One natural sub-module, p6_shift_parity: a loadable left-shift register with running XOR. It has load, shift, data_in, msb_out and parity_out.
- The FSM, counter and output registers stay in the top module.

Test Plan:
- Reset=0 for 15 ns, then release, start=1 with data_in=8'hA5, PARITY_EVEN=1 -> tx_bit sequence 1,0,1,0,0,1,0,1 then parity 0; tx_valid high for 9 cycles; done pulse on the 10th cycle after acceptance; status 0→1(×8)→2→3→0.
- data_in=8'h07, PARITY_EVEN=1 -> data 0,0,0,0,0,1,1,1, parity 1. The P5 receiver on tx_bit reports even total ones at the end of the frame.
- data_in=8'h00 with PARITY_EVEN=0 -> eight 0 bits then parity 1; same data with PARITY_EVEN=1 -> parity 0.
- start pulsed again during DATA cycle 3 with data_in=8'hFF -> ignored; the frame in progress completes unchanged, and no second frame follows without a new start in IDLE.
- reset driven low during DATA cycle 4 -> tx_bit, tx_valid, busy, done and status go to 0 without waiting for a clock edge; no done pulse; a new start after release sends a complete, correct frame.
- start held high with data_in=8'h3C -> frames repeat every DATA_W+3 cycles, each with parity 0 and one done pulse per frame.
